fb_muldiv: RTL and testbench
============================

FB_MULDIV -- requirements
Module: fb_muldiv

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port flush, input, 1, which kills any in-flight operation.
REQ-005 The block SHALL have port in_valid, input, 1, meaning a request is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the unit can accept a request.
REQ-007 The block SHALL have port alu_control, input, 19, the decoded ALU control vector; only bits 18:11 are used (18 mul, 17 mulh, 16 mulhsu, 15 mulhu, 14 div, 13 divu, 12 rem, 11 remu).
REQ-008 The block SHALL have ports src_a and src_b, input, XLEN each, for the rs1 and rs2 operands.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The block SHALL have port result, output, XLEN, the operation result.
REQ-012 The block SHALL have port busy, output, 1, asserted whenever the state is not IDLE.

Function
REQ-013 A request SHALL be accepted on a rising edge where in_valid=1, in_ready=1 and alu_control[18:11]!=0; a request with alu_control[18:11]=0 SHALL be ignored.
REQ-014 If more than one RV32M bit is set, the highest bit number SHALL win (mul > mulh > ... > remu).
REQ-015 Operands and the op SHALL be registered at accept; src_a, src_b and alu_control are don't-care afterwards.
REQ-016 The FSM SHALL have three states, IDLE, CALC and DONE, with these transitions:
- IDLE->CALC on accept;
- CALC->DONE when the iteration counter reaches its last value;
- DONE->IDLE when out_ready=1;
- any state->IDLE on flush.
REQ-017 in_ready SHALL equal 1 only in IDLE; out_valid SHALL equal 1 only in DONE.
REQ-018 result SHALL be held stable throughout DONE until the handshake completes.
REQ-019 Division SHALL be radix-2 restoring on magnitudes, taking 32 CALC cycles, with out_valid first high 33 edges after the accept edge.
REQ-020 For signed division, the quotient sign SHALL be sign(a) XOR sign(b) and the remainder sign SHALL follow the dividend, with the fixup folded into the last CALC cycle.
REQ-021 On divide-by-zero, div/divu SHALL return 0xFFFFFFFF and rem/remu SHALL return src_a, with the same latency and no exception.
REQ-022 On signed overflow (0x80000000 / 0xFFFFFFFF), div SHALL return 0x80000000 and rem SHALL return 0.
REQ-023 Multiply SHALL form a 64-bit product, with mulh treating signed×signed, mulhsu signed×unsigned and mulhu unsigned×unsigned.
REQ-024 mul SHALL return product[31:0] and the mulh* ops SHALL return product[63:32].
REQ-025 If flush and accept occur on the same edge, flush SHALL win: no request is taken and in_ready stays 1.
REQ-026 A flush in DONE SHALL drop the result without out_valid handshake.
REQ-027 No new request SHALL be accepted on the same edge the DONE->IDLE handshake completes; one idle cycle is mandatory.

Reset
REQ-028 Asserting rst_n=0 SHALL asynchronously force the state to IDLE, with in_ready=1, out_valid=0, busy=0, result=0, counter=0 and operand registers=0.
REQ-029 A reset during CALC or DONE SHALL abandon the operation with no output.
REQ-030 Deassertion SHALL be synchronous to clk through the codebase's reset synchronizer, external to this block.

Configuration
REQ-031 With macro FB_MUL_FAST_EN defined, all multiply ops SHALL use a single-cycle 33×33 signed array multiplier, spending 1 CALC cycle with out_valid at accept+2.
REQ-032 Without FB_MUL_FAST_EN, multiply SHALL be iterative shift-add over magnitudes with sign fixup, spending 32 CALC cycles with out_valid at accept+33, identical to division.
REQ-033 Division behaviour SHALL be unaffected by FB_MUL_FAST_EN.

Structure
REQ-034 fb_defines.v SHALL hold the alu_control RV32M bit-position constants (18..11), the FSM state encodings and the divide-by-zero result constant.
REQ-035 The restoring divider datapath (remainder and quotient registers, step, sign fixup) SHALL be one sub-module, fb_div_iter, sequenced by fb_muldiv's FSM and counter.

Verification
REQ-036 divu 100/7 -> out_valid at accept+33, result=14; remu same operands -> result=2.
REQ-037 div 0x80000000/0xFFFFFFFF -> 0x80000000; rem same -> 0; div 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5.
REQ-038 mulh 0xFFFFFFFF×0xFFFFFFFF -> 0; mulhu same -> 0xFFFFFFFE; mulhsu same -> 0xFFFFFFFF; mul -7×3 -> 0xFFFFFFEB; latency 2 with FB_MUL_FAST_EN, 33 without.
REQ-039 out_ready held 0 for 10 cycles in DONE -> result stable, in_ready=0; out_ready=1 -> IDLE next edge, and a back-to-back in_valid is accepted one edge later.
REQ-040 flush at CALC cycle 15 of div -> IDLE next edge, no out_valid; a new request completes correctly; rst_n pulse mid-CALC -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fb_muldiv_pkg.sv
// Shared constants, op encoding and decode helper for the RV32M multiply/divide unit.
// Holds the alu_control bit positions, FSM encodings and the divide-by-zero result.
package fb_muldiv_pkg;

  localparam int ALU_MUL    = 18;
  localparam int ALU_MULH   = 17;
  localparam int ALU_MULHSU = 16;
  localparam int ALU_MULHU  = 15;
  localparam int ALU_DIV    = 14;
  localparam int ALU_DIVU   = 13;
  localparam int ALU_REM    = 12;
  localparam int ALU_REMU   = 11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [31:0] DIV_ZERO_RESULT = 32'hFFFF_FFFF;
  localparam logic [4:0]  ITER_LAST       = 5'd31;

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  // sel is alu_control[18:11]; the highest set bit wins.
  function automatic op_e decode_op(input logic [7:0] sel);
    op_e op;
    op = OP_REMU;
    if (sel[ALU_MUL-11])         op = OP_MUL;
    else if (sel[ALU_MULH-11])   op = OP_MULH;
    else if (sel[ALU_MULHSU-11]) op = OP_MULHSU;
    else if (sel[ALU_MULHU-11])  op = OP_MULHU;
    else if (sel[ALU_DIV-11])    op = OP_DIV;
    else if (sel[ALU_DIVU-11])   op = OP_DIVU;
    else if (sel[ALU_REM-11])    op = OP_REM;
    return op;
  endfunction

endpackage

// File: rtl/fb_div_iter.sv
// Radix-2 restoring divider on magnitudes; one quotient bit per step.
// final_result carries the sign-fixed (and divide-by-zero) answer for the current step.
module fb_div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        first,
  input  logic        is_signed,
  input  logic        want_rem,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] final_result
);
  import fb_muldiv_pkg::*;

  logic [31:0] rem_q, quo_q;
  logic [31:0] a_mag, b_mag, rem_cur, quo_cur, rem_nxt, quo_nxt;
  logic [32:0] shifted;
  logic        a_neg, b_neg, fits;

  // NOTE: every variable gets a value on every path, so no latch is inferred.
  always_comb begin
    a_neg   = is_signed & dividend[31];
    b_neg   = is_signed & divisor[31];
    a_mag   = a_neg ? -dividend : dividend;
    b_mag   = b_neg ? -divisor : divisor;
    // The first step seeds from the operands so no separate load cycle is needed.
    rem_cur = first ? '0 : rem_q;
    quo_cur = first ? a_mag : quo_q;
    shifted = {rem_cur, quo_cur[31]};
    fits    = shifted >= {1'b0, b_mag};
    rem_nxt = fits ? shifted[31:0] - b_mag : shifted[31:0];
    quo_nxt = {quo_cur[30:0], fits};
    if (divisor == '0)
      final_result = want_rem ? dividend : DIV_ZERO_RESULT;
    else if (want_rem)
      final_result = a_neg ? -rem_nxt : rem_nxt;
    else
      final_result = (a_neg ^ b_neg) ? -quo_nxt : quo_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

endmodule

// File: rtl/fb_muldiv.sv
// RV32M multiply/divide unit with valid/ready handshakes and an IDLE/CALC/DONE FSM.
// Define FB_MUL_FAST_EN for a single-cycle multiplier; default is 32-step shift-add.
module fb_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [18:0]     alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  import fb_muldiv_pkg::*;

  logic [1:0]      state;
  logic [4:0]      cnt, last_cnt;
  logic [XLEN-1:0] op_a, op_b;
  op_e             op;
  logic            accept, is_div, calc_last, first;
  logic            a_signed, b_signed;
  logic [31:0]     div_result, mul_result;
  logic [63:0]     product;
  logic            unused_ctrl;

  assign unused_ctrl = ^alu_control[10:0];

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  // Flush beats a same-edge request.
  assign accept    = in_valid && in_ready && (alu_control[18:11] != '0) && !flush;
  assign is_div    = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign first     = (cnt == '0);
  assign a_signed  = (op == OP_MULH) || (op == OP_MULHSU);
  assign b_signed  = (op == OP_MULH);

`ifdef FB_MUL_FAST_EN
  logic signed [65:0] prod_full;
  logic               unused_prod;

  assign last_cnt    = is_div ? ITER_LAST : 5'd0;
  assign prod_full   = $signed({a_signed & op_a[31], op_a}) * $signed({b_signed & op_b[31], op_b});
  assign product     = prod_full[63:0];
  assign unused_prod = ^prod_full[65:64];
`else
  logic [31:0] mul_hi, mul_lo, ma_mag, mb_mag, hi_cur, lo_cur, hi_nxt, lo_nxt;
  logic [32:0] sum;
  logic [63:0] prod_mag;
  logic        m_neg;

  assign last_cnt = ITER_LAST;

  // Shift-add on magnitudes: {hi,lo} starts as {0,|b|} and shifts right each step.
  always_comb begin
    ma_mag   = (a_signed & op_a[31]) ? -op_a : op_a;
    mb_mag   = (b_signed & op_b[31]) ? -op_b : op_b;
    m_neg    = (a_signed & op_a[31]) ^ (b_signed & op_b[31]);
    hi_cur   = first ? '0 : mul_hi;
    lo_cur   = first ? mb_mag : mul_lo;
    sum      = {1'b0, hi_cur} + (lo_cur[0] ? {1'b0, ma_mag} : 33'd0);
    hi_nxt   = sum[32:1];
    lo_nxt   = {sum[0], lo_cur[31:1]};
    prod_mag = {hi_nxt, lo_nxt};
    product  = m_neg ? -prod_mag : prod_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_hi <= '0;
      mul_lo <= '0;
    end else if (state == S_CALC && !is_div) begin
      mul_hi <= hi_nxt;
      mul_lo <= lo_nxt;
    end
  end
`endif

  assign mul_result = (op == OP_MUL) ? product[31:0] : product[63:32];
  assign calc_last  = (state == S_CALC) && (cnt == last_cnt);

  fb_div_iter u_div (
    .clk          (clk),
    .rst_n        (rst_n),
    .step         ((state == S_CALC) && is_div),
    .first        (first),
    .is_signed    ((op == OP_DIV) || (op == OP_REM)),
    .want_rem     ((op == OP_REM) || (op == OP_REMU)),
    .dividend     (op_a),
    .divisor      (op_b),
    .final_result (div_result)
  );

  // NOTE: operand and result registers are reset as well, so outputs are defined straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op     <= OP_MUL;
      result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state <= S_CALC;
          cnt   <= '0;
          op_a  <= src_a;
          op_b  <= src_b;
          op    <= decode_op(alu_control[18:11]);
        end
        S_CALC: if (calc_last) begin
          state  <= S_DONE;
          cnt    <= '0;
          result <= is_div ? div_result : mul_result;
        end else begin
          cnt <= cnt + 5'd1;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_muldiv.sv
// Self-checking bench for fb_muldiv: directed RV32M corner cases plus randomized traffic
// compared every cycle against an arithmetic reference model and completion-time tracker.
module tb_fb_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [18:0] alu_control;
  logic [31:0] src_a, src_b, result;

  int n_vec = 0;
  int n_bad = 0;

`ifdef FB_MUL_FAST_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  localparam logic [18:0] C_MUL    = 19'b1 << 18;
  localparam logic [18:0] C_MULH   = 19'b1 << 17;
  localparam logic [18:0] C_MULHSU = 19'b1 << 16;
  localparam logic [18:0] C_MULHU  = 19'b1 << 15;
  localparam logic [18:0] C_DIV    = 19'b1 << 14;
  localparam logic [18:0] C_DIVU   = 19'b1 << 13;
  localparam logic [18:0] C_REM    = 19'b1 << 12;
  localparam logic [18:0] C_REMU   = 19'b1 << 11;

  always #5 clk = ~clk;

  fb_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [18:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, ua, ub;
    int          ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    r  = '0;
    if (c[18]) begin p = ua * ub; r = p[31:0]; end
    else if (c[17]) begin p = sa * sb; r = p[63:32]; end
    else if (c[16]) begin p = sa * ub; r = p[63:32]; end
    else if (c[15]) begin p = ua * ub; r = p[63:32]; end
    else if (c[14]) begin
      if (b == 0) r = 32'hFFFF_FFFF;
      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
      else r = ia / ib;
    end
    else if (c[13]) r = (b == 0) ? 32'hFFFF_FFFF : a / b;
    else if (c[12]) begin
      if (b == 0) r = a;
      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
      else r = ia % ib;
    end
    else if (c[11]) r = (b == 0) ? a : a % b;
    return r;
  endfunction

  function automatic int model_lat(input logic [18:0] c);
    return (c[18:15] != 0) ? MUL_LAT : DIV_LAT;
  endfunction

  // Compare process: predicts accepts and completion times, checks outputs every cycle.
  int          mon_edge = 0;
  int          mon_due  = 0;
  bit          mon_active = 0;
  bit          mon_pend   = 0;
  logic [18:0] mon_ctrl;
  logic [31:0] mon_a, mon_b, mon_exp;

  always @(negedge clk) begin
    mon_edge++;
    if (!rst_n) begin
      mon_active = 0;
      mon_pend   = 0;
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst result", result, 32'd0);
    end else begin
      if (mon_pend) begin
        mon_active = 1;
        mon_pend   = 0;
        mon_exp    = model(mon_ctrl, mon_a, mon_b);
        mon_due    = mon_edge + model_lat(mon_ctrl) - 1;
      end
      if (mon_active) begin
        check("mon in_ready", 32'(in_ready), 32'd0);
        check("mon busy", 32'(busy), 32'd1);
        if (mon_edge < mon_due) begin
          check("mon early out_valid", 32'(out_valid), 32'd0);
        end else begin
          check("mon out_valid", 32'(out_valid), 32'd1);
          check("mon result", result, mon_exp);
        end
      end else begin
        check("mon idle in_ready", 32'(in_ready), 32'd1);
        check("mon idle out_valid", 32'(out_valid), 32'd0);
        check("mon idle busy", 32'(busy), 32'd0);
      end
      if (flush) mon_active = 0;
      else if (mon_active && mon_edge >= mon_due && out_ready) mon_active = 0;
      else if (!mon_active && in_valid && alu_control[18:11] != 0) begin
        mon_pend = 1;
        mon_ctrl = alu_control;
        mon_a    = src_a;
        mon_b    = src_b;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [18:0] c, input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    while (!in_ready && g < 100) begin tick(); g++; end
    in_valid = 1; alu_control = c; src_a = a; src_b = b;
    tick();
    in_valid = 0; alu_control = 19'($urandom); src_a = $urandom; src_b = $urandom;
    check("accept busy", 32'(busy), 32'd1);
  endtask

  // Called one tick after the accept edge; returns edges counted from the accept edge.
  task automatic await_result(input string name, input logic [31:0] lit, output int n);
    n = 1;
    while (!out_valid && n < 100) begin tick(); n++; end
    check(name, result, lit);
  endtask

  task automatic run_lit(input string name, input logic [18:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit, input int lat);
    int n;
    check({name, " model"}, model(c, a, b), lit);
    send(c, a, b);
    await_result(name, lit, n);
    check({name, " latency"}, 32'(n), 32'(lat));
    tick();
  endtask

  function automatic logic [18:0] rand_ctrl();
    logic [18:0] c;
    int k;
    c = 19'($urandom);
    c[18:11] = 8'h00;
    k = $urandom_range(0, 19);
    if (k < 16) c[11 + (k % 8)] = 1'b1;
    else if (k < 19) c[18:11] = 8'($urandom);
    return c;
  endfunction

  function automatic logic [31:0] rand_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int n;
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    alu_control = '0; src_a = '0; src_b = '0;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset result", result, 32'd0);
    tick(); tick();
    rst_n = 1;
    tick();

    run_lit("divu 100/7", C_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
    run_lit("remu 100/7", C_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);
    run_lit("div ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT);
    run_lit("rem ovf", C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, DIV_LAT);
    run_lit("div 5/0", C_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, DIV_LAT);
    run_lit("rem 5/0", C_REM, 32'd5, 32'd0, 32'd5, DIV_LAT);
    run_lit("div -7/2", C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
    run_lit("rem -7/2", C_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
    run_lit("mulh -1*-1", C_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, MUL_LAT);
    run_lit("mulhu", C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_lit("mulhsu", C_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_lit("mul -7*3", C_MUL, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFEB, MUL_LAT);
    run_lit("priority mul", C_MUL | C_DIV | C_REMU, 32'd6, 32'd7, 32'd42, MUL_LAT);
    run_lit("priority div", C_DIV | C_REMU, 32'd100, 32'd7, 32'd14, DIV_LAT);

    // Stall in DONE, then back-to-back request during the handshake.
    out_ready = 0;
    send(C_DIVU, 32'd1000, 32'd33);
    await_result("stall divu", 32'd30, n);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall result", result, 32'd30);
      check("stall in_ready", 32'(in_ready), 32'd0);
      check("stall out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1;
    in_valid = 1; alu_control = C_DIVU; src_a = 32'd50; src_b = 32'd5;
    tick();
    check("handshake idle in_ready", 32'(in_ready), 32'd1);
    check("handshake out_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 0;
    check("b2b accepted", 32'(busy), 32'd1);
    await_result("b2b divu", 32'd10, n);
    check("b2b latency", 32'(n), 32'(DIV_LAT));
    tick();

    // Flush in the 15th CALC cycle of a divide.
    send(C_DIV, 32'd1000, 32'd7);
    repeat (14) tick();
    flush = 1;
    tick();
    flush = 0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    check("flush out_valid", 32'(out_valid), 32'd0);
    repeat (3) tick();
    run_lit("after flush div", C_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, DIV_LAT);

    // Flush and request on the same edge: flush wins.
    in_valid = 1; alu_control = C_DIVU; src_a = 32'd9; src_b = 32'd3; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    check("flush+accept busy", 32'(busy), 32'd0);
    check("flush+accept in_ready", 32'(in_ready), 32'd1);

    // A request with no RV32M bit set is ignored.
    in_valid = 1; alu_control = 19'h007FF; src_a = 32'd9; src_b = 32'd3;
    tick();
    in_valid = 0;
    check("zero ctrl busy", 32'(busy), 32'd0);

    // Flush while DONE drops the result.
    out_ready = 0;
    send(C_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    await_result("flush-done mulhu", model(C_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), n);
    flush = 1;
    tick();
    flush = 0; out_ready = 1;
    check("flush done out_valid", 32'(out_valid), 32'd0);
    check("flush done in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-CALC.
    send(C_DIVU, 32'hDEAD_BEEF, 32'd3);
    repeat (5) tick();
    rst_n = 0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd1);
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst result", result, 32'd0);
    tick();
    rst_n = 1;
    tick();
    run_lit("after reset remu", C_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);

    // Randomized traffic, checked by the compare process.
    for (int c = 0; c < 6000; c++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 2) == 0);
      alu_control = rand_ctrl();
      src_a = rand_opnd();
      src_b = rand_opnd();
    end
    tick();
    in_valid = 0; flush = 0; out_ready = 1;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("drain busy", 32'(busy), 32'd0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
